// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions for the bitcoin_hash datapath.
// Contents:
//   state_t        - job sequencer states
//   K[0:63]        - round constants
//   IV[0:7]        - initial hash value H(0)
//   bsig0/bsig1    - round functions Sigma0/Sigma1
//   ssig0/ssig1    - message schedule functions sigma0/sigma1
package sha256_pkg;

  typedef enum logic [2:0] {
    IDLE, READ, BLK1, BLK2, HASH2, WRITE, DONE
  } state_t;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round.
// Ports:
//   a..h               in  32  current working variables
//   w                  in  32  message schedule word W[t]
//   k                  in  32  round constant K[t]
//   a_next..h_next     out 32  working variables after the round
module sha256_round
  import sha256_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  input  logic [31:0] e,
  input  logic [31:0] f,
  input  logic [31:0] g,
  input  logic [31:0] h,
  input  logic [31:0] w,
  input  logic [31:0] k,
  output logic [31:0] a_next,
  output logic [31:0] b_next,
  output logic [31:0] c_next,
  output logic [31:0] d_next,
  output logic [31:0] e_next,
  output logic [31:0] f_next,
  output logic [31:0] g_next,
  output logic [31:0] h_next
);

  logic [31:0] t1;
  logic [31:0] t2;

  always_comb begin
    t1     = h + bsig1(e) + ((e & f) ^ (~e & g)) + k + w;
    t2     = bsig0(a) + ((a & b) ^ (a & c) ^ (b & c));
    a_next = t1 + t2;
    b_next = a;
    c_next = b;
    d_next = c;
    e_next = d + t1;
    f_next = e;
    g_next = f;
    h_next = g;
  end

endmodule

// File: rtl/bitcoin_hash.sv
// Bitcoin double SHA-256 over a 19-word header for nonces 0..NUM_NONCES-1.
// Reads the header from message_addr+0..18, computes the midstate once on
// lane 0, then runs block 2 and the second hash for all nonces in parallel
// and writes H0 of each final digest to output_addr+n.
// Ports:
//   clk             in   1  clock
//   reset_n         in   1  asynchronous active-low reset
//   start           in   1  job request, sampled in IDLE only
//   message_addr    in  16  header base word address
//   output_addr     in  16  first result word address
//   done            out  1  job complete, held until the next accepted start
//   mem_clk         out  1  memory clock (clk)
//   mem_we          out  1  memory write enable
//   mem_addr        out 16  memory word address
//   mem_write_data  out 32  memory write data
//   mem_read_data   in  32  memory read data, one cycle after the address
module bitcoin_hash
  import sha256_pkg::*;
#(
  parameter int unsigned NUM_NONCES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] message_addr,
  input  logic [15:0] output_addr,
  output logic        done,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam logic [15:0] READ_LAST = 16'd19;
  localparam logic [15:0] RND_LAST  = 16'd63;
  localparam logic [15:0] WR_LAST   = 16'(NUM_NONCES - 1);

  state_t      state;
  state_t      state_next;
  logic [15:0] cnt;
  logic [31:0] k_cur;

  logic [31:0] st    [NUM_NONCES][8];
  logic [31:0] nx    [NUM_NONCES][8];
  logic [31:0] w     [NUM_NONCES][16];
  logic [31:0] w_new [NUM_NONCES];
  logic [31:0] mid   [8];
  logic [31:0] tail  [3];
  logic [31:0] res   [NUM_NONCES];

  assign mem_clk        = clk;
  assign k_cur          = K[cnt[5:0]];
  assign mem_write_data = mem_we ? res[0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = READ;
      READ:    if (cnt == READ_LAST) state_next = BLK1;
      BLK1:    if (cnt == RND_LAST) state_next = BLK2;
      BLK2:    if (cnt == RND_LAST) state_next = HASH2;
      HASH2:   if (cnt == RND_LAST) state_next = WRITE;
      WRITE:   if (cnt == WR_LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Memory outputs are registered one cycle ahead so each WRITE cycle
  // presents exactly its own address/data, and each READ cycle its address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      done     <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
    end else begin
      cnt <= (state_next != state) ? '0 : cnt + 16'd1;
      case (state)
        IDLE: if (start) begin
          done     <= 1'b0;
          mem_addr <= message_addr;
        end
        READ: if (cnt < READ_LAST - 16'd1) mem_addr <= mem_addr + 16'd1;
        HASH2: if (cnt == RND_LAST) begin
          mem_we   <= 1'b1;
          mem_addr <= output_addr;
        end
        WRITE: begin
          if (cnt == WR_LAST) begin
            mem_we <= 1'b0;
            done   <= 1'b1;
          end else begin
            mem_addr <= mem_addr + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int unsigned n = 0; n < NUM_NONCES; n++)
      w_new[n] = ssig1(w[n][14]) + w[n][9] + ssig0(w[n][1]) + w[n][0];
  end

  for (genvar g = 0; g < NUM_NONCES; g++) begin : g_lane
    sha256_round u_round (
      .a(st[g][0]), .b(st[g][1]), .c(st[g][2]), .d(st[g][3]),
      .e(st[g][4]), .f(st[g][5]), .g(st[g][6]), .h(st[g][7]),
      .w(w[g][0]), .k(k_cur),
      .a_next(nx[g][0]), .b_next(nx[g][1]), .c_next(nx[g][2]), .d_next(nx[g][3]),
      .e_next(nx[g][4]), .f_next(nx[g][5]), .g_next(nx[g][6]), .h_next(nx[g][7])
    );
  end

  always_ff @(posedge clk) begin
    case (state)
      READ: begin
        // Lane 0 window and tail form one 19-word shift chain; read data is
        // valid from cnt 1, so after cnt 19 word 0 sits at w[0][0].
        if (cnt != '0) begin
          for (int unsigned i = 0; i < 15; i++) w[0][i] <= w[0][i + 1];
          w[0][15] <= tail[0];
          tail[0]  <= tail[1];
          tail[1]  <= tail[2];
          tail[2]  <= mem_read_data;
        end
        if (cnt == READ_LAST)
          for (int unsigned i = 0; i < 8; i++) st[0][i] <= IV[i];
      end
      BLK1: begin
        for (int unsigned i = 0; i < 15; i++) w[0][i] <= w[0][i + 1];
        w[0][15] <= w_new[0];
        for (int unsigned i = 0; i < 8; i++) st[0][i] <= nx[0][i];
        if (cnt == RND_LAST) begin
          for (int unsigned i = 0; i < 8; i++) mid[i] <= IV[i] + nx[0][i];
          for (int unsigned n = 0; n < NUM_NONCES; n++) begin
            for (int unsigned i = 0; i < 8; i++) st[n][i] <= IV[i] + nx[0][i];
            w[n][0] <= tail[0];
            w[n][1] <= tail[1];
            w[n][2] <= tail[2];
            w[n][3] <= n;
            w[n][4] <= 32'h80000000;
            for (int unsigned i = 5; i < 15; i++) w[n][i] <= '0;
            w[n][15] <= 32'd640;
          end
        end
      end
      BLK2, HASH2: begin
        for (int unsigned n = 0; n < NUM_NONCES; n++) begin
          for (int unsigned i = 0; i < 15; i++) w[n][i] <= w[n][i + 1];
          w[n][15] <= w_new[n];
          for (int unsigned i = 0; i < 8; i++) st[n][i] <= nx[n][i];
          if (cnt == RND_LAST) begin
            if (state == BLK2) begin
              for (int unsigned i = 0; i < 8; i++) begin
                w[n][i]  <= mid[i] + nx[n][i];
                st[n][i] <= IV[i];
              end
              w[n][8] <= 32'h80000000;
              for (int unsigned i = 9; i < 15; i++) w[n][i] <= '0;
              w[n][15] <= 32'd256;
            end else begin
              res[n] <= IV[0] + nx[n][0];
            end
          end
        end
      end
      WRITE: begin
        for (int unsigned n = 0; n + 1 < NUM_NONCES; n++) res[n] <= res[n + 1];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bitcoin_hash.sv
// Self-checking bench for bitcoin_hash (NUM_NONCES = 16).
// A behavioural SHA-256 model fills a scoreboard with the expected
// {address, H0} write for every nonce when a job starts; each DUT write
// pops and compares the head entry.
module tb_bitcoin_hash;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] message_addr;
  logic [15:0] output_addr;
  logic        done;
  logic        mem_clk;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  always #5 clk = ~clk;

  bitcoin_hash #(.NUM_NONCES(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .message_addr(message_addr), .output_addr(output_addr),
    .done(done), .mem_clk(mem_clk), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  logic [31:0] mem [65536];
  always @(posedge mem_clk) mem_read_data <= mem[mem_addr];

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [255:0] HIV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

  int n_pass  = 0;
  int n_total = 0;
  logic [47:0] sbq [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] wv [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    for (int i = 0; i < 16; i++) wv[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++)
      wv[i] = (rr(wv[i-2], 17) ^ rr(wv[i-2], 19) ^ (wv[i-2] >> 10)) + wv[i-7]
            + (rr(wv[i-15], 7) ^ rr(wv[i-15], 18) ^ (wv[i-15] >> 3)) + wv[i-16];
    {a, b, c, d, e, f, g, h} = hin;
    for (int i = 0; i < 64; i++) begin
      t1 = h + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + KT[i] + wv[i];
      t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {a + hin[255:224], b + hin[223:192], c + hin[191:160], d + hin[159:128],
            e + hin[127:96],  f + hin[95:64],   g + hin[63:32],   h + hin[31:0]};
  endfunction

  function automatic logic [31:0] h0_model(input logic [607:0] hp, input logic [31:0] nonce);
    logic [255:0] md, dg, hh;
    md = compress(HIV, hp[607:96]);
    dg = compress(md, {hp[95:0], nonce, 32'h80000000, 320'h0, 32'd640});
    hh = compress(HIV, {dg, 32'h80000000, 192'h0, 32'd256});
    return hh[255:224];
  endfunction

  task automatic load_hdr(input logic [15:0] base, input logic [607:0] hp);
    for (int i = 0; i < 19; i++) mem[base + 16'(i)] = hp[607 - 32*i -: 32];
  endtask

  // hold: cycles start stays high; abort_at: cycle at which reset_n is pulled
  // low (0 = run to completion). A stray start pulse is always sent mid-job.
  task automatic run_job(input logic [15:0] maddr, input logic [15:0] oaddr,
                         input int hold, input int abort_at);
    logic [607:0] hp;
    logic [47:0]  e;
    int cycles, writes;
    bit fin;
    for (int i = 0; i < 19; i++) hp[607 - 32*i -: 32] = mem[maddr + 16'(i)];
    for (int n = 0; n < 16; n++) sbq.push_back({oaddr + 16'(n), h0_model(hp, 32'(n))});
    message_addr = maddr;
    output_addr  = oaddr;
    start        = 1'b1;
    cycles = 0; writes = 0; fin = 1'b0;
    while (!fin && cycles < 400) begin
      @(negedge clk);
      cycles++;
      start = (cycles < hold) || (cycles == 100);
      if (cycles == 1) check("done_clear", 64'(done), 64'(0));
      if (mem_we === 1'b1) begin
        writes++;
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          check("write", 64'({mem_addr, mem_write_data}), 64'(e));
        end
      end
      if (abort_at != 0 && cycles == abort_at) begin
        reset_n = 1'b0;
        #1;
        check("abort_done", 64'(done), 64'(0));
        check("abort_we", 64'(mem_we), 64'(0));
        check("abort_addr", 64'(mem_addr), 64'(0));
        check("abort_wdata", 64'(mem_write_data), 64'(0));
        fin = 1'b1;
      end else if (done === 1'b1) begin
        fin = 1'b1;
      end
    end
    start = 1'b0;
    if (abort_at != 0) begin
      repeat (3) begin
        @(negedge clk);
        if (mem_we !== 1'b0) writes++;
      end
      check("abort_no_writes", 64'(writes), 64'(0));
      sbq.delete();
      reset_n = 1'b1;
      @(negedge clk);
    end else begin
      check("done_set", 64'(done), 64'(1));
      check("latency_le_300", 64'(cycles - 1 <= 300), 64'(1));
      check("write_count", 64'(writes), 64'(16));
      check("scoreboard_empty", 64'(sbq.size()), 64'(0));
      sbq.delete();
      repeat (4) begin
        @(negedge clk);
        check("done_hold", 64'(done), 64'(1));
        check("idle_no_write", 64'(mem_we), 64'(0));
      end
    end
  endtask

  logic [607:0] seed_hdr;
  logic [607:0] gen_hdr;
  logic [31:0]  sw;

  initial begin
    reset_n      = 1'b0;
    start        = 1'b0;
    message_addr = '0;
    output_addr  = '0;
    repeat (3) @(negedge clk);
    check("rst_done", 64'(done), 64'(0));
    check("rst_we", 64'(mem_we), 64'(0));
    check("rst_addr", 64'(mem_addr), 64'(0));
    check("rst_wdata", 64'(mem_write_data), 64'(0));
    reset_n = 1'b1;
    @(negedge clk);

    gen_hdr = {32'h01000000, 256'h0,
               256'h3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a,
               32'h29ab5f49, 32'hffff001d};
    check("model_genesis_h0", 64'(h0_model(gen_hdr, 32'h1dac2b7c)), 64'(32'h6fe28c0a));

    sw = 32'h01234567;
    for (int i = 0; i < 19; i++) begin
      seed_hdr[607 - 32*i -: 32] = sw;
      sw = {sw[30:0], sw[31]};
    end

    load_hdr(16'd0, seed_hdr);
    run_job(16'd0, 16'd1000, 1, 0);

    load_hdr(16'd200, gen_hdr);
    run_job(16'd200, 16'd3000, 2, 0);

    load_hdr(16'hFFF0, seed_hdr);
    run_job(16'hFFF0, 16'hFFF8, 1, 0);

    load_hdr(16'd500, gen_hdr);
    run_job(16'd500, 16'd600, 1, 110);
    run_job(16'd500, 16'd600, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bitcoin_hash.md
BITCOIN_HASH -- requirements
Module: bitcoin_hash

Interface
REQ-001 Parameter NUM_NONCES, default 16: number of nonces hashed per job, nonces 0..NUM_NONCES-1.
REQ-002 clk  in  1: single clock; all state updates on its rising edge.
REQ-003 reset_n  in  1: asynchronous, active-low reset.
REQ-004 start  in  1: job request; sampled only in IDLE; may stay high for several cycles.
REQ-005 message_addr  in  16: word address of the 19-word block header.
REQ-006 output_addr  in  16: word address of the first result word.
REQ-007 done  out  1: job complete.
REQ-008 mem_clk  out  1: memory clock, driven directly from clk.
REQ-009 mem_we  out  1: 1 = write, 0 = read.
REQ-010 mem_addr  out  16: memory word address.
REQ-011 mem_write_data  out  32: write data.
REQ-012 mem_read_data  in  32: read data, valid on the cycle after the address is presented (synchronous 1-cycle read).

Function
REQ-013 Algorithm: Bitcoin double SHA-256 over the 80-byte header, one result per nonce.
- Block 1 = header words 0..15, initial hash = standard SHA-256 IV, giving midstate M.
- Block 2 per nonce n = words 16..18, then n, 0x80000000, ten zero words, 640.
- Block 2 starts from M and gives digest D[n].
- Hash 2 = D[n] as words 0..7, then 0x80000000, six zeros, 256; starts from the IV.
REQ-014 Round function and message schedule SHALL follow FIPS 180-4 SHA-256 exactly: 64 K constants, Σ/σ rotations, modulo-2^32 additions.
REQ-015 Final hash of each block SHALL be the IV or midstate plus the working variables, word by word, modulo 2^32.
REQ-016 Output: word 0 (H0) of hash 2 for nonce n SHALL be written to output_addr+n, n = 0..NUM_NONCES-1; no other address is written.
REQ-017 Header words SHALL be read from message_addr+0..18; all address arithmetic is 16-bit and wraps.
REQ-018 State machine:
- IDLE -> READ on start.
- READ (19 reads) -> BLK1 (64 rounds).
- BLK1 -> BLK2 (64 rounds, all nonces in parallel).
- BLK2 -> HASH2 (64 rounds, all nonces in parallel).
- HASH2 -> WRITE (NUM_NONCES writes) -> DONE.
- DONE -> IDLE.
REQ-019 Each state computes one SHA-256 round per clock; message words are generated on the fly with a 16-word sliding window.
REQ-020 Total latency from start sampled to done high SHALL be at most 300 cycles for NUM_NONCES=16.
REQ-021 done SHALL assert after the last write completes and stay high until the next accepted start; the next start clears it and begins a new job.
REQ-022 start SHALL be ignored while a job is running.
REQ-023 mem_we SHALL be high only in WRITE cycles; mem_write_data SHALL be valid in the same cycle as mem_we and mem_addr.

Reset
REQ-024 On reset_n low the block SHALL enter IDLE asynchronously with done=0, mem_we=0, mem_addr=0, mem_write_data=0.
REQ-025 Reset mid-job SHALL abort the job with no further writes; a new start afterwards SHALL run a full, correct job.

Structure
REQ-026 A shared package sha256_pkg SHALL hold the K[0:63] table, the IV constants and the state-encoding enum.
REQ-027 One sub-module, sha256_round, SHALL implement the combinational round: inputs a..h, w, k; output next a..h.
REQ-028 There SHALL be NUM_NONCES instances of sha256_round; instance 0 is reused for BLK1.

Verification
REQ-029 Seed test: header word0=0x01234567, word i = word i-1 rotated left 1, message_addr=0, output_addr=1000 -> 16 words at 1000..1015 equal the golden-model H0 for nonces 0..15; done high.
REQ-030 Known vector: header equal to Bitcoin block 0 with its known nonce placed at n -> H0 matches the published digest word.
REQ-031 start held high for 2 cycles -> exactly one job runs and exactly 16 writes occur.
REQ-032 reset_n pulsed low during BLK2 -> no writes occur; a restart produces correct results.
REQ-033 message_addr=0xFFF0 -> reads wrap to 0x0000..0x0002 and results are correct.
REQ-034 Cycle count from start to done is at most 300.
